// File: rtl/unsigned_divider.sv
// Multi-cycle unsigned divider: restoring radix-2, one quotient bit per cycle, MSB first.
// Divide-by-zero completes in one cycle with RISC-V DIVU/REMU results.
module unsigned_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // quo_q doubles as the dividend shift register: its MSB is the next dividend
    // bit, and resolved quotient bits shift in at the LSB.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        qbit  = (trial >= {1'b0, dvs_q});
        rem_d = qbit ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && !flush) begin
                        dvs_q  <= divisor;
                        cnt_q  <= CW'(WIDTH - 1);
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            quo_q   <= '1;
                            rem_q   <= dividend;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            quo_q   <= dividend;
                            rem_q   <= '0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
